// File: rtl/clk_en_pkg.sv
// -----------------------------------------------------------------------------
// clk_en_pkg
// Shared definitions for the clock-enable scheduler:
//   ch_state_e       per-channel FSM state (OFF, RUN, RUN_PEND)
//   DIV_UART_115200  divisor giving a 115200 baud tick from the 50 MHz clock
//   DIV_1KHZ         divisor giving a 1 kHz tick (display refresh / timer)
//   STAT_W           width of the optional per-channel tick statistics counter
//   ch_idx_w()       channel-select width, never less than 1 bit
// Optional feature macro used by the other files: CLK_EN_SCHED_STAT_EN.
// -----------------------------------------------------------------------------
package clk_en_pkg;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        RUN      = 2'd1,
        RUN_PEND = 2'd2
    } ch_state_e;

    localparam int unsigned DIV_UART_115200 = 434;
    localparam int unsigned DIV_1KHZ        = 50000;
    localparam int unsigned STAT_W          = 16;

    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_en_sched_if.sv
// -----------------------------------------------------------------------------
// clk_en_sched_if
// Divisor configuration write port (valid/ready).
//   i_cfg_valid  write request                  (master -> slave)
//   i_cfg_ch     target channel                 (master -> slave)
//   i_cfg_div    divisor, 0 switches channel off (master -> slave)
//   o_cfg_ready  write accepted with valid      (slave -> master)
// Parameters NUM_CH and DIV_W must match the scheduler instance.
// -----------------------------------------------------------------------------
interface clk_en_sched_if
    import clk_en_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16
);
    localparam int CH_W = ch_idx_w(NUM_CH);

    logic             i_cfg_valid;
    logic             o_cfg_ready;
    logic [CH_W-1:0]  i_cfg_ch;
    logic [DIV_W-1:0] i_cfg_div;

    modport master (
        output i_cfg_valid, i_cfg_ch, i_cfg_div,
        input  o_cfg_ready
    );

    modport slave (
        input  i_cfg_valid, i_cfg_ch, i_cfg_div,
        output o_cfg_ready
    );

endinterface

// File: rtl/clk_en_ch.sv
// -----------------------------------------------------------------------------
// clk_en_ch
// One tick channel: active divisor, period counter, shadow divisor and FSM.
//   clk50       system clock
//   i_reset     asynchronous active-low reset
//   i_wr        accepted configuration write for this channel
//   i_div       divisor carried by the write
//   i_sync      phase-align pulse (counter restarts at 0)
//   o_tick      one-cycle enable strobe, decoded from flops only
//   o_pending   shadow divisor waiting for the next period boundary
//   o_tick_cnt  saturating tick count (only with CLK_EN_SCHED_STAT_EN)
// -----------------------------------------------------------------------------
module clk_en_ch
    import clk_en_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic              clk50,
    input  logic              i_reset,
    input  logic              i_wr,
    input  logic [DIV_W-1:0]  i_div,
    input  logic              i_sync,
    output logic              o_tick,
    output logic              o_pending
`ifdef CLK_EN_SCHED_STAT_EN
   ,output logic [STAT_W-1:0] o_tick_cnt
`endif
);

    ch_state_e        r_state;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_shd;

    logic             w_tick;
    logic             w_apply;
    logic [DIV_W-1:0] w_apply_div;
    logic [DIV_W-1:0] w_cnt_nxt;

    // r_div is never 0 outside OFF, so div-1 cannot underflow when it matters.
    assign w_tick    = (r_state != OFF) && (r_cnt == r_div - 1'b1);
    assign w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;

    // A new divisor is applied at a period boundary of a pending channel, or
    // at once when sync arrives (a same-cycle write counts as arriving first).
    assign w_apply     = ((r_state == RUN) && i_wr && i_sync) ||
                         ((r_state == RUN_PEND) && (i_sync || w_tick));
    assign w_apply_div = (r_state == RUN_PEND) ? r_shd : i_div;

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk50 or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= OFF;
            r_div   <= '0;
            r_cnt   <= '0;
            r_shd   <= '0;
        end else if (w_apply) begin
            r_shd <= '0;
            r_cnt <= '0;
            if (w_apply_div != '0) begin
                r_div   <= w_apply_div;
                r_state <= RUN;
            end else begin
                r_div   <= '0;
                r_state <= OFF;
            end
        end else begin
            case (r_state)
                OFF: begin
                    if (i_wr && (i_div != '0)) begin
                        r_div   <= i_div;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_cnt <= i_sync ? '0 : w_cnt_nxt;
                    // A write landing on a tick cycle waits for the next tick.
                    if (i_wr) begin
                        r_shd   <= i_div;
                        r_state <= RUN_PEND;
                    end
                end
                RUN_PEND: r_cnt <= w_cnt_nxt;
                default:  r_state <= OFF;
            endcase
        end
    end

    assign o_tick    = w_tick;
    assign o_pending = (r_state == RUN_PEND);

`ifdef CLK_EN_SCHED_STAT_EN
    logic [STAT_W-1:0] r_tick_cnt;

    always_ff @(posedge clk50 or negedge i_reset) begin
        if (!i_reset) begin
            r_tick_cnt <= '0;
        end else if (i_sync) begin
            r_tick_cnt <= '0;
        end else if (w_tick && (r_tick_cnt != '1)) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign o_tick_cnt = r_tick_cnt;
`endif

endmodule

// File: rtl/clk_en_sched.sv
// -----------------------------------------------------------------------------
// clk_en_sched
// Programmable clock-enable scheduler: NUM_CH independent one-cycle tick
// strobes derived from clk50, divisors written at run time.
//   clk50       50 MHz system clock
//   i_reset     asynchronous active-low reset
//   cfg         configuration write port (clk_en_sched_if.slave)
//   i_sync      single-cycle pulse, phase-aligns all running channels
//   o_tick      per-channel tick strobes
//   o_pending   per-channel "unapplied divisor held" flags
//   o_tick_cnt  per-channel saturating tick counts (CLK_EN_SCHED_STAT_EN only)
// Optional feature macro: CLK_EN_SCHED_STAT_EN.
// -----------------------------------------------------------------------------
module clk_en_sched
    import clk_en_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16
) (
    input  logic                           clk50,
    input  logic                           i_reset,
    clk_en_sched_if.slave                  cfg,
    input  logic                           i_sync,
    output logic [NUM_CH-1:0]              o_tick,
    output logic [NUM_CH-1:0]              o_pending
`ifdef CLK_EN_SCHED_STAT_EN
   ,output logic [NUM_CH-1:0][STAT_W-1:0]  o_tick_cnt
`endif
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_wr;
    logic              w_accept;

    // An out-of-range channel selects nothing, so it reads as ready and the
    // write is silently dropped.
    assign cfg.o_cfg_ready = ~|(w_sel & o_pending);
    assign w_accept        = cfg.i_cfg_valid && cfg.o_cfg_ready;
    assign w_wr            = w_sel & {NUM_CH{w_accept}};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_sel[g] = (cfg.i_cfg_ch == CH_W'(g));

        clk_en_ch #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clk50      (clk50),
            .i_reset    (i_reset),
            .i_wr       (w_wr[g]),
            .i_div      (cfg.i_cfg_div),
            .i_sync     (i_sync),
            .o_tick     (o_tick[g]),
            .o_pending  (o_pending[g])
`ifdef CLK_EN_SCHED_STAT_EN
           ,.o_tick_cnt (o_tick_cnt[g])
`endif
        );
    end

endmodule

// File: tb/tb_clk_en_sched.sv
// -----------------------------------------------------------------------------
// tb_clk_en_sched
// Self-checking bench for clk_en_sched. A 4-channel instance carries the main
// scenarios; a 3-channel instance exercises the out-of-range channel select.
// Outputs are sampled 1 time unit after the rising edge. A tick seen after
// edge e belongs to clock cycle e+1 (the cycle that ends at edge e+1).
// -----------------------------------------------------------------------------
module tb_clk_en_sched;

    logic       clk50 = 1'b0;
    logic       i_reset;
    logic       i_sync;
    logic       i_sync3;
    logic [3:0] o_tick;
    logic [3:0] o_pending;
    logic [2:0] o_tick3;
    logic [2:0] o_pending3;
`ifdef CLK_EN_SCHED_STAT_EN
    logic [3:0][15:0] o_tick_cnt;
    logic [2:0][15:0] o_tick_cnt3;
`endif

    always #10 clk50 = ~clk50;

    clk_en_sched_if #(.NUM_CH(4), .DIV_W(16)) cfg_if ();
    clk_en_sched_if #(.NUM_CH(3), .DIV_W(16)) cfg3_if ();

    clk_en_sched #(.NUM_CH(4), .DIV_W(16)) dut (
        .clk50      (clk50),
        .i_reset    (i_reset),
        .cfg        (cfg_if),
        .i_sync     (i_sync),
        .o_tick     (o_tick),
        .o_pending  (o_pending)
`ifdef CLK_EN_SCHED_STAT_EN
       ,.o_tick_cnt (o_tick_cnt)
`endif
    );

    clk_en_sched #(.NUM_CH(3), .DIV_W(16)) dut3 (
        .clk50      (clk50),
        .i_reset    (i_reset),
        .cfg        (cfg3_if),
        .i_sync     (i_sync3),
        .o_tick     (o_tick3),
        .o_pending  (o_pending3)
`ifdef CLK_EN_SCHED_STAT_EN
       ,.o_tick_cnt (o_tick_cnt3)
`endif
    );

    typedef struct {
        logic        valid;
        logic [1:0]  ch;
        logic [15:0] div;
        logic        sync;
        logic        exp_ready;
        logic [3:0]  exp_tick;
        logic [3:0]  exp_pend;
    } vec_t;

    typedef struct {
        logic [3:0] tick;
        logic [3:0] pend;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   exp_cyc[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   edge_n   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic step();
        @(posedge clk50);
        edge_n++;
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] ch, input logic [15:0] div, input logic s);
        cfg_if.i_cfg_valid = v;
        cfg_if.i_cfg_ch    = ch;
        cfg_if.i_cfg_div   = div;
        i_sync             = s;
    endtask

    task automatic apply_reset();
        drive(1'b0, 2'd0, 16'd0, 1'b0);
        #2 i_reset = 1'b0;
        step();
        step();
        i_reset = 1'b1;
        edge_n  = 0;
    endtask

    function automatic vec_t mk(input logic v, input logic [1:0] ch, input logic [15:0] div,
                                input logic s, input logic rdy, input logic [3:0] t,
                                input logic [3:0] p);
        vec_t r;
        r.valid = v; r.ch = ch; r.div = div; r.sync = s;
        r.exp_ready = rdy; r.exp_tick = t; r.exp_pend = p;
        return r;
    endfunction

    function automatic logic [3:0] sync_mask(input int j);
        // ch3 at div 3 and ch0 at div 7, both counting from 0 right after sync
        return {(j % 3 == 2), 2'b00, (j % 7 == 6)};
    endfunction

    task automatic run_vectors(input string tag);
        exp_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].ch, vecs[i].div, vecs[i].sync);
            #1;
            check($sformatf("%s[%0d].ready", tag, i), 32'(cfg_if.o_cfg_ready), 32'(vecs[i].exp_ready));
            sb.push_back('{vecs[i].exp_tick, vecs[i].exp_pend});
            step();
            e = sb.pop_front();
            check($sformatf("%s[%0d].tick", tag, i), 32'(o_tick), 32'(e.tick));
            check($sformatf("%s[%0d].pend", tag, i), 32'(o_pending), 32'(e.pend));
        end
        drive(1'b0, 2'd0, 16'd0, 1'b0);
        vecs.delete();
    endtask

    initial begin
        i_reset = 1'b1;
        i_sync3 = 1'b0;
        cfg3_if.i_cfg_valid = 1'b0;
        cfg3_if.i_cfg_ch    = 2'd0;
        cfg3_if.i_cfg_div   = 16'd0;
        drive(1'b0, 2'd0, 16'd0, 1'b0);
        #5;

        // ---- reset state ------------------------------------------------
        apply_reset();
        check("rst.tick", 32'(o_tick), 32'h0);
        check("rst.pend", 32'(o_pending), 32'h0);
        check("rst.ready", 32'(cfg_if.o_cfg_ready), 32'h1);

        // ---- ch0 div 5 written at edge 10: ticks in cycles 15, 20, 25 ----
        while (edge_n < 9) step();
        drive(1'b1, 2'd0, 16'd5, 1'b0);
        exp_cyc.push_back(15);
        exp_cyc.push_back(20);
        exp_cyc.push_back(25);
        step();
        drive(1'b0, 2'd0, 16'd0, 1'b0);
        while (edge_n < 26) begin
            logic exp0;
            exp0 = (exp_cyc.size() > 0) && (exp_cyc[0] == edge_n + 1);
            if (exp0) void'(exp_cyc.pop_front());
            check($sformatf("div5.tick@cyc%0d", edge_n + 1), 32'(o_tick), {31'd0, exp0});
            step();
        end
        check("div5.all_seen", 32'(exp_cyc.size()), 32'd0);

        // ---- ch1 div 4 -> 2 mid-period; blocked write while pending -----
        apply_reset();
        vecs.push_back(mk(1, 1, 16'd4, 0, 1, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 1, 16'd0, 0, 1, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 1, 16'd0, 0, 1, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 1, 16'd0, 0, 1, 4'b0010, 4'b0000));
        vecs.push_back(mk(0, 1, 16'd0, 0, 1, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 1, 16'd2, 0, 1, 4'b0000, 4'b0010));
        vecs.push_back(mk(0, 0, 16'd0, 0, 1, 4'b0000, 4'b0010));
        vecs.push_back(mk(1, 1, 16'd9, 0, 0, 4'b0010, 4'b0010));
        vecs.push_back(mk(0, 1, 16'd0, 0, 0, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 1, 16'd0, 0, 1, 4'b0010, 4'b0000));
        vecs.push_back(mk(0, 1, 16'd0, 0, 1, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 1, 16'd0, 0, 1, 4'b0010, 4'b0000));
        run_vectors("chg");

        // ---- ch2 div 3 -> 0 written on a tick cycle; sync+write on ch0 --
        apply_reset();
        vecs.push_back(mk(1, 2, 16'd3, 0, 1, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 2, 16'd0, 0, 1, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 2, 16'd0, 0, 1, 4'b0100, 4'b0000));
        vecs.push_back(mk(1, 2, 16'd0, 0, 1, 4'b0000, 4'b0100));
        vecs.push_back(mk(0, 2, 16'd0, 0, 0, 4'b0000, 4'b0100));
        vecs.push_back(mk(0, 2, 16'd0, 0, 0, 4'b0100, 4'b0100));
        vecs.push_back(mk(0, 2, 16'd0, 0, 0, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 2, 16'd0, 0, 1, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 2, 16'd0, 0, 1, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 2, 16'd0, 0, 1, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 0, 16'd3, 1, 1, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 0, 16'd0, 0, 1, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 0, 16'd0, 0, 1, 4'b0001, 4'b0000));
        vecs.push_back(mk(1, 0, 16'd2, 1, 1, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 0, 16'd0, 0, 1, 4'b0001, 4'b0000));
        vecs.push_back(mk(0, 0, 16'd0, 0, 1, 4'b0000, 4'b0000));
        run_vectors("off");

        // ---- sync alignment: ch0 div 7, ch3 div 3 ------------------------
        apply_reset();
        drive(1'b1, 2'd0, 16'd7, 1'b0);
        step();
        drive(1'b1, 2'd3, 16'd3, 1'b0);
        step();
        drive(1'b0, 2'd0, 16'd0, 1'b0);
        repeat (3) step();
        // ch0 cnt 4, ch3 cnt 0: neither counter is at a wrap point
        check("sync.pre", 32'(o_tick), 32'h0);
        i_sync = 1'b1;
        step();
        i_sync = 1'b0;
        for (int j = 0; j <= 8; j++) begin
            check($sformatf("sync1.j%0d", j), 32'(o_tick), 32'(sync_mask(j)));
            if (j < 8) step();
        end
        // ch3 is ticking in this cycle; the sync must not hide that tick
        i_sync = 1'b1;
        #1;
        check("sync2.same_cycle_tick", 32'(o_tick), 32'h8);
        step();
        i_sync = 1'b0;
        for (int j = 0; j <= 13; j++) begin
            check($sformatf("sync2.j%0d", j), 32'(o_tick), 32'(sync_mask(j)));
            step();
        end

        // ---- ch1 div 1, reset asserted mid-stream -----------------------
        apply_reset();
        drive(1'b1, 2'd1, 16'd1, 1'b0);
        step();
        drive(1'b0, 2'd1, 16'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("div1.tick%0d", k), 32'(o_tick), 32'h2);
            step();
        end
        #4 i_reset = 1'b0;
        #1;
        check("midrst.tick", 32'(o_tick), 32'h0);
        check("midrst.ready", 32'(cfg_if.o_cfg_ready), 32'h1);
        step();
        i_reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("postrst.tick%0d", k), 32'(o_tick), 32'h0);
        end
        check("postrst.pend", 32'(o_pending), 32'h0);

        // ---- out-of-range channel on the 3-channel instance -------------
        apply_reset();
        cfg3_if.i_cfg_valid = 1'b1;
        cfg3_if.i_cfg_ch    = 2'd3;
        cfg3_if.i_cfg_div   = 16'd2;
        #1;
        check("oor.ready", 32'(cfg3_if.o_cfg_ready), 32'h1);
        step();
        cfg3_if.i_cfg_ch = 2'd2;
        step();
        cfg3_if.i_cfg_valid = 1'b0;
        check("oor.tick_after_ignored", 32'(o_tick3), 32'h0);
        check("oor.pend", 32'(o_pending3), 32'h0);
        step();
        check("oor.ch2_tick", 32'(o_tick3), 32'h4);

`ifdef CLK_EN_SCHED_STAT_EN
        // ---- tick statistics saturation and clear -----------------------
        apply_reset();
        drive(1'b1, 2'd0, 16'd1, 1'b0);
        step();
        drive(1'b0, 2'd0, 16'd0, 1'b0);
        repeat (70000) step();
        check("stat.sat", 32'(o_tick_cnt[0]), 32'hFFFF);
        check("stat.idle_ch", 32'(o_tick_cnt[1]), 32'h0);
        i_sync = 1'b1;
        step();
        i_sync = 1'b0;
        check("stat.clear", 32'(o_tick_cnt[0]), 32'h0);
        step();
        check("stat.recount", 32'(o_tick_cnt[0]), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_en_sched.md
# clk_en_sched

Programmable clock-enable scheduler for the DE-10 Standard design. Derives up to NUM_CH independent one-cycle tick strobes from the 50 MHz board clock, replacing per-consumer fabric clock dividers with a single clock domain plus enables. Divisors are configured at run time through a valid/ready write port. Updates are applied glitch-free at period boundaries. Consumers include the UART baud tick, the LCD/7-seg refresh and the timer prescaler.

## Interface
Parameters:
- NUM_CH, 4, number of tick channels (1..8)
- DIV_W, 16, divisor width in bits

Ports:
- clk50  in  1  50 MHz system clock
- i_reset  in  1  reset; asynchronous, active-low
- i_cfg_valid  in  1  config write request
- o_cfg_ready  out  1  write accepted when high together with i_cfg_valid
- i_cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel; values ≥ NUM_CH are accepted and ignored
- i_cfg_div  in  DIV_W  divisor; 0 = channel off
- i_sync  in  1  single-cycle pulse; phase-align all channels
- o_tick  out  NUM_CH  per-channel one-cycle enable strobes
- o_pending  out  NUM_CH  channel holds an unapplied divisor

## Operation
- Each channel has three registers: active divisor `div`, counter `cnt` (DIV_W bits), and shadow divisor `shd`.
- Per-channel FSM states:
  - OFF: cnt held at 0, no ticks.
  - RUN: cnt counts 0..div-1 and wraps.
  - RUN_PEND: same counting as RUN, with shd valid.
- Tick decode:
  - o_tick[i] = (state != OFF) && (cnt == div-1).
  - Decoded from flops only; no combinational path from inputs.
  - div = 1 gives a tick every cycle.
- o_cfg_ready = !o_pending[i_cfg_ch]. For an out-of-range channel, o_cfg_ready = 1.
- Accepted write to a channel in OFF:
  - div = 0: no-op.
  - div ≠ 0: load div and cnt = 0, go to RUN.
- Accepted write to a channel in RUN: store shd, go to RUN_PEND.
- Leaving RUN_PEND on a tick cycle:
  - shd ≠ 0: div = shd, cnt = 0, go to RUN.
  - shd = 0: go to OFF.
- i_sync:
  - Every non-OFF channel: cnt = 0.
  - A channel in RUN_PEND applies shd immediately, with the same rules as above.
  - No tick is suppressed retroactively; ticks decoded in the sync cycle still appear.
- Sync and an accepted write in the same cycle: the write takes effect as if it arrived before the sync. An OFF or RUN channel loads div immediately with cnt = 0.
- Tick and accepted write in the same cycle on a RUN channel: the write goes to shd and is applied at the next tick, not the current one.
- Arithmetic: cnt increments modulo div. No wrap beyond div-1 is possible, because div is only replaced at cnt = 0.

## Timing
- Reset values (async assert, sync release):
  - All channels OFF, div = 0, cnt = 0, shd = 0.
  - o_tick = 0, o_pending = 0, o_cfg_ready = 1.
- Write accepted at edge N to an OFF channel with divisor D: first tick in cycle N+D, then every D cycles.
- Write accepted while in RUN: new period starts on the cycle after the next current tick.
- o_pending rises the cycle after acceptance and falls the cycle after application.
- i_sync at edge S: cnt = 0 from S+1; the first post-sync tick is in cycle S+div.
- Reset mid-operation: all outputs return to reset values immediately. Pending writes are lost.

## Configuration
- Macro: CLK_EN_SCHED_STAT_EN.
- Defined:
  - Adds output port o_tick_cnt (NUM_CH × 16 bits), a per-channel saturating tick count.
  - Counts clear on reset and on i_sync.
  - Counts saturate at 16'hFFFF.
- Undefined: the port and the counters are absent. All other behaviour is identical.

## Structure
- Shared package clk_en_pkg:
  - ch_state_e enum (OFF, RUN, RUN_PEND).
  - Default divisor constants for consumers: DIV_UART_115200 = 434, DIV_1KHZ = 50000.
- One sub-module, clk_en_ch: a single channel (FSM, cnt, div, shd, tick decode), instantiated NUM_CH times via generate.
- The top level holds the ready/decode logic and fans out i_sync.

## Test plan
- Reset, then write ch0 div = 5 at edge 10: o_tick[0] high in cycles 15, 20, 25; other ticks remain 0.
- ch1 running div = 4; write div = 2 mid-period: o_pending[1] = 1, o_cfg_ready low for ch1. After the next div-4 tick, ticks come every 2 cycles and o_pending[1] = 0.
- ch2 running div = 3; write div = 0: one more tick, then ch2 goes OFF with no further ticks.
- ch0 div = 7 and ch3 div = 3 free-running; pulse i_sync at edge S: ch3 ticks at S+3, ch0 ticks at S+7, with both counters aligned from S+1.
- Write ch1 div = 1: tick every cycle. Assert i_reset mid-stream: o_tick = 0 immediately, and the channel stays OFF after release.
- With CLK_EN_SCHED_STAT_EN: ch0 div = 1 for 70000 cycles gives o_tick_cnt[0] = 16'hFFFF. An i_sync pulse then clears it to 0.
